bus_xfer_sequencer: RTL and testbench

//  Issues register-to-register moves over the shared 32-bit datapath bus.

---
 rtl/bus_xfer_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// Register-to-register move sequencer: queues (src,dst) commands and replays each as DRIVE then LATCH bus phases.
// Optional macro BUS_XFER_ERR_EN adds an err output and drops commands carrying an out-of-range endpoint index.
module bus_xfer_sequencer #(
    parameter int DEPTH = 4,
    parameter int NSEL  = 24,
    parameter int SEL_W = 5
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SEL_W-1:0]       cmd_src,
    input  logic [SEL_W-1:0]       cmd_dst,
    input  logic                   hold,
    output logic [NSEL-1:0]        src_out,
    output logic [NSEL-1:0]        dst_in,
    output logic                   done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
`ifdef BUS_XFER_ERR_EN
    ,
    output logic                   err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    srcMem_q [DEPTH];
    logic [SEL_W-1:0]    dstMem_q [DEPTH];
    logic [PTR_W-1:0]    rdPtr_q, wrPtr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SEL_W-1:0]    curSrc_q, curSrc_d;
    logic [SEL_W-1:0]    curDst_q, curDst_d;
    logic [NSEL-1:0]     srcOut_q, srcOut_d;
    logic [NSEL-1:0]     dstIn_q, dstIn_d;
    logic                done_q, done_d;
    logic                push, pop, notEmpty;
    logic [SEL_W-1:0]    headSrc, headDst;
`ifdef BUS_XFER_ERR_EN
    logic                err_q, err_d;
`endif

    function automatic logic [NSEL-1:0] oneHot(input logic [SEL_W-1:0] idx);
        logic [NSEL-1:0] vec;
        vec = '0;
        for (int i = 0; i < NSEL; i++) begin
            vec[i] = (int'(idx) == i);
        end
        return vec;
    endfunction

`ifdef BUS_XFER_ERR_EN
    function automatic logic inRange(input logic [SEL_W-1:0] idx);
        return int'(idx) < NSEL;
    endfunction
`endif

    // Readiness comes only from the registered count, so a full FIFO refuses even when popping.
    assign cmd_ready = (count_q < CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign notEmpty  = (count_q != '0);
    assign headSrc   = srcMem_q[rdPtr_q];
    assign headDst   = dstMem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            srcMem_q[wrPtr_q] <= cmd_src;
            dstMem_q[wrPtr_q] <= cmd_dst;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
        end
    end

    // Strobes for the coming cycle are computed here so every output leaves a flop.
    always_comb begin
        state_d  = state_q;
        curSrc_d = curSrc_q;
        curDst_d = curDst_q;
        srcOut_d = srcOut_q;
        dstIn_d  = dstIn_q;
        done_d   = 1'b0;
        pop      = 1'b0;
`ifdef BUS_XFER_ERR_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE, LATCH: begin
                state_d  = IDLE;
                srcOut_d = '0;
                dstIn_d  = '0;
                if (notEmpty && !hold) begin
                    pop      = 1'b1;
                    curSrc_d = headSrc;
                    curDst_d = headDst;
`ifdef BUS_XFER_ERR_EN
                    if (!inRange(headSrc) || !inRange(headDst)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = DRIVE;
                        srcOut_d = oneHot(headSrc);
                    end
`else
                    state_d  = DRIVE;
                    srcOut_d = oneHot(headSrc);
`endif
                end
            end
            DRIVE: begin
                if (!hold) begin
                    state_d  = LATCH;
                    srcOut_d = oneHot(curSrc_q);
                    dstIn_d  = oneHot(curDst_q);
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                srcOut_d = '0;
                dstIn_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            curSrc_q <= '0;
            curDst_q <= '0;
            srcOut_q <= '0;
            dstIn_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            curSrc_q <= curSrc_d;
            curDst_q <= curDst_d;
            srcOut_q <= srcOut_d;
            dstIn_q  <= dstIn_d;
            done_q   <= done_d;
        end
    end

`ifdef BUS_XFER_ERR_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign src_out = srcOut_q;
    assign dst_in  = dstIn_q;
    assign done    = done_q;
    assign count   = count_q;
    assign busy    = (state_q != IDLE) || notEmpty;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Self-checking bench for bus_xfer_sequencer: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based model of the move semantics.
module tb_bus_xfer_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        cmdValid;
    logic        cmdReady;
    logic [4:0]  cmdSrc;
    logic [4:0]  cmdDst;
    logic        hold;
    logic [23:0] srcOut;
    logic [23:0] dstIn;
    logic        done;
    logic        busy;
    logic [2:0]  count;
`ifdef BUS_XFER_ERR_EN
    logic        err;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int src;
        int dst;
    } move_t;

    // Model: pending moves in a queue, the move on the bus, and which phase (0 none, 1 drive, 2 latch) it is in.
    move_t       modelQ[$];
    move_t       curMove;
    int          phase;
    logic [23:0] expSrc;
    logic [23:0] expDst;
    logic        expDone;
    logic        expErr;
    int          doneCount;

    bus_xfer_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_src   (cmdSrc),
        .cmd_dst   (cmdDst),
        .hold      (hold),
        .src_out   (srcOut),
        .dst_in    (dstIn),
        .done      (done),
        .busy      (busy),
        .count     (count)
`ifdef BUS_XFER_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] endpointMask(input int idx);
        return (idx < 24) ? (24'h1 << idx) : 24'h0;
    endfunction

    task automatic modelReset();
        modelQ.delete();
        phase   = 0;
        expSrc  = '0;
        expDst  = '0;
        expDone = 1'b0;
        expErr  = 1'b0;
    endtask

    task automatic modelStep(input bit v, input int s, input int d, input bit h);
        bit accept;
        accept  = v && (modelQ.size() < 4);
        expDone = 1'b0;
        expErr  = 1'b0;
        if (phase == 1) begin
            if (!h) phase = 2;
        end else begin
            phase = 0;
            if (modelQ.size() > 0 && !h) begin
                curMove = modelQ.pop_front();
`ifdef BUS_XFER_ERR_EN
                if (curMove.src >= 24 || curMove.dst >= 24) expErr = 1'b1;
                else phase = 1;
`else
                phase = 1;
`endif
            end
        end
        if (accept) modelQ.push_back('{src: s, dst: d});
        expSrc = (phase != 0) ? endpointMask(curMove.src) : 24'h0;
        expDst = (phase == 2) ? endpointMask(curMove.dst) : 24'h0;
        expDone = (phase == 2);
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_src"},   32'(srcOut), 32'(expSrc));
        checkVal({tag, "_dst"},   32'(dstIn), 32'(expDst));
        checkVal({tag, "_done"},  32'(done), 32'(expDone));
        checkVal({tag, "_count"}, 32'(count), 32'(modelQ.size()));
        checkVal({tag, "_ready"}, 32'(cmdReady), 32'(modelQ.size() < 4));
        checkVal({tag, "_busy"},  32'(busy), 32'((phase != 0) || (modelQ.size() != 0)));
        checkVal({tag, "_srcOneHot"}, 32'($countones(srcOut) <= 1), 32'd1);
        checkVal({tag, "_dstOneHot"}, 32'($countones(dstIn) <= 1), 32'd1);
`ifdef BUS_XFER_ERR_EN
        checkVal({tag, "_err"},   32'(err), 32'(expErr));
`endif
    endtask

    // Inputs are set at the falling edge, the model advances, and outputs are checked at the next falling edge.
    task automatic applyStimulus(input bit v, input int s, input int d, input bit h, input string tag);
        cmdValid = v;
        cmdSrc   = 5'(s);
        cmdDst   = 5'(d);
        hold     = h;
        modelStep(v, s, d, h);
        @(posedge clk);
        @(negedge clk);
        doneCount += int'(done);
        checkOutput(tag);
    endtask

    initial begin
        int rs, rd;
        bit rv, rh;

        clr      = 1'b1;
        cmdValid = 1'b0;
        cmdSrc   = '0;
        cmdDst   = '0;
        hold     = 1'b0;
        doneCount = 0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
        clr = 1'b0;

        // Single move 3 -> 20.
        applyStimulus(1, 3, 20, 0, "t2push");
        applyStimulus(0, 0, 0, 0, "t2drive");
        checkVal("t2driveConst", 32'(srcOut), 32'h000008);
        applyStimulus(0, 0, 0, 0, "t2latch");
        checkVal("t2latchDstConst", 32'(dstIn), 32'h100000);
        checkVal("t2latchDoneConst", 32'(done), 32'd1);
        applyStimulus(0, 0, 0, 0, "t2idle");

        // Fill the FIFO under hold, offer a fifth, then drain.
        for (int i = 0; i < 4; i++) applyStimulus(1, i, i + 8, 1, "t3fill");
        applyStimulus(1, 9, 9, 1, "t3refuse");
        checkVal("t3fullCount", 32'(count), 32'd4);
        checkVal("t3fullReady", 32'(cmdReady), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, "t3drain");
        checkVal("t3doneTotal", 32'(doneCount), 32'd4);

        // Hold asserted through DRIVE for three cycles.
        applyStimulus(1, 5, 6, 0, "t4push");
        applyStimulus(0, 0, 0, 0, "t4drive");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, "t4hold");
        checkVal("t4heldSrc", 32'(srcOut), 32'h000020);
        applyStimulus(0, 0, 0, 0, "t4latch");
        applyStimulus(0, 0, 0, 0, "t4idle");

        // Same endpoint on both sides.
        applyStimulus(1, 23, 23, 0, "t5push");
        applyStimulus(0, 0, 0, 0, "t5drive");
        applyStimulus(0, 0, 0, 0, "t5latch");
        checkVal("t5srcConst", 32'(srcOut), 32'h800000);
        checkVal("t5dstConst", 32'(dstIn), 32'h800000);
        applyStimulus(0, 0, 0, 0, "t5idle");

        // Out-of-range source index.
        applyStimulus(1, 30, 2, 0, "t6push");
        applyStimulus(0, 0, 0, 0, "t6phase1");
        applyStimulus(0, 0, 0, 0, "t6phase2");
        applyStimulus(0, 0, 0, 0, "t6idle");

        // Asynchronous clear in LATCH with a command still queued.
        applyStimulus(1, 1, 2, 0, "t1pushA");
        applyStimulus(1, 4, 5, 0, "t1pushB");
        applyStimulus(0, 0, 0, 0, "t1latch");
        clr = 1'b1;
        #1;
        modelReset();
        checkOutput("t1clr");
        @(negedge clk);
        clr = 1'b0;
        checkOutput("t1afterClr");

        // Random traffic with occasional out-of-range indices and holds.
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
            rd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
            rh = ($urandom_range(0, 3) == 0);
            applyStimulus(rv, rs, rd, rh, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
